// File: rtl/id_ex_pipe_if.sv
// One valid/ready channel carrying a control field and a payload.
// master drives the beat, slave returns ready.
interface id_ex_pipe_if #(
  parameter int CTL_W  = 9,
  parameter int DATA_W = 138
);
  logic              valid;
  logic              ready;
  logic [CTL_W-1:0]  ctl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctl, output data, input ready);
  modport slave  (input valid, input ctl, input data, output ready);
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX stage register with valid/ready handshake, synchronous flush that inserts bubbles,
// and an optional two-entry skid buffer that keeps ready off the combinational path.
module id_ex_pipe #(
  parameter int CTL_W  = 9,
  parameter int DATA_W = 138,
  parameter bit SKID   = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  id_ex_pipe_if.slave  in_if,
  id_ex_pipe_if.master out_if
);

  logic [CTL_W-1:0]  main_ctl_q, main_ctl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              main_valid;
  logic              in_ready;
  logic              in_fire;

  assign in_fire      = in_if.valid & in_ready & ~flush;
  assign in_if.ready  = in_ready;
  assign out_if.valid = main_valid;
  // Bubbles carry zero control so EX/MEM/WB see a NOP.
  assign out_if.ctl   = main_valid ? main_ctl_q : '0;
  assign out_if.data  = main_data_q;

  generate
    if (SKID) begin : g_skid
      typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

      state_t            state_q, state_d;
      logic [CTL_W-1:0]  skid_ctl_q, skid_ctl_d;
      logic [DATA_W-1:0] skid_data_q, skid_data_d;

      assign main_valid = (state_q != ST_EMPTY);
      // Decoded from the state register only, so no path from out_ready.
      assign in_ready   = (state_q != ST_SKID);

      always_comb begin
        state_d     = state_q;
        main_ctl_d  = main_ctl_q;
        main_data_d = main_data_q;
        skid_ctl_d  = skid_ctl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
          state_d    = ST_EMPTY;
          main_ctl_d = '0;
          skid_ctl_d = '0;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (in_fire) begin
                main_ctl_d  = in_if.ctl;
                main_data_d = in_if.data;
                state_d     = ST_FULL;
              end
            end
            ST_FULL: begin
              if (in_fire && out_if.ready) begin
                main_ctl_d  = in_if.ctl;
                main_data_d = in_if.data;
              end else if (in_fire) begin
                skid_ctl_d  = in_if.ctl;
                skid_data_d = in_if.data;
                state_d     = ST_SKID;
              end else if (out_if.ready) begin
                state_d = ST_EMPTY;
              end
            end
            ST_SKID: begin
              if (out_if.ready) begin
                main_ctl_d  = skid_ctl_q;
                main_data_d = skid_data_q;
                state_d     = ST_FULL;
              end
            end
            default: state_d = ST_EMPTY;
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q     <= ST_EMPTY;
          main_ctl_q  <= '0;
          main_data_q <= '0;
          skid_ctl_q  <= '0;
          skid_data_q <= '0;
        end else begin
          state_q     <= state_d;
          main_ctl_q  <= main_ctl_d;
          main_data_q <= main_data_d;
          skid_ctl_q  <= skid_ctl_d;
          skid_data_q <= skid_data_d;
        end
      end
    end else begin : g_single
      logic valid_q, valid_d;

      assign main_valid = valid_q;
      assign in_ready   = out_if.ready | ~valid_q;

      always_comb begin
        valid_d     = valid_q;
        main_ctl_d  = main_ctl_q;
        main_data_d = main_data_q;
        if (flush) begin
          valid_d    = 1'b0;
          main_ctl_d = '0;
        end else if (in_fire) begin
          valid_d     = 1'b1;
          main_ctl_d  = in_if.ctl;
          main_data_d = in_if.data;
        end else if (valid_q && out_if.ready) begin
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q     <= 1'b0;
          main_ctl_q  <= '0;
          main_data_q <= '0;
        end else begin
          valid_q     <= valid_d;
          main_ctl_q  <= main_ctl_d;
          main_data_q <= main_data_d;
        end
      end
    end
  endgenerate

endmodule
